// File: rtl/ram_arbiter.sv
// Arbiter in front of the single-port board RAM: display > clear engine > game.
// Define RAM_ARB_CLEAR_EN to build the full-RAM clear engine; without it clr_start is ignored.
module ram_arbiter #(
    parameter int AW = 16,
    parameter int DW = 8,
    parameter int DEPTH = 65026,
    parameter logic [DW-1:0] CLR_VAL = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          disp_req,
    input  logic [AW-1:0] disp_addr,
    output logic          disp_valid,
    output logic [DW-1:0] disp_data,
    input  logic          gp_req,
    input  logic          gp_we,
    input  logic [AW-1:0] gp_addr,
    input  logic [DW-1:0] gp_wdata,
    output logic          gp_ack,
    output logic          gp_rvalid,
    output logic [DW-1:0] gp_rdata,
    input  logic          clr_start,
    output logic          clr_busy,
    output logic [AW-1:0] ram_a,
    output logic [DW-1:0] ram_d,
    output logic          ram_we,
    input  logic [DW-1:0] ram_q
);

    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {OWN_NONE, OWN_DISP, OWN_GAME} owner_t;

    owner_t        owner;
    logic          disp_win;
    logic          game_win;
    logic          game_wr_ok;
    logic          clr_wr;
    logic [AW-1:0] clr_addr;
    logic [AW-1:0] a_last;
    logic [DW-1:0] disp_hold;
    logic [DW-1:0] gp_hold;

`ifdef RAM_ARB_CLEAR_EN
    // state    | meaning
    // ST_IDLE  | no clear running, game port may be granted
    // ST_CLEAR | writing CLR_VAL at clr_addr on every cycle the display leaves free
    typedef enum logic {ST_IDLE, ST_CLEAR} clr_state_t;

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    clr_state_t    state, state_nxt;
    logic [AW-1:0] cnt_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            clr_addr <= '0;
        end else begin
            state    <= state_nxt;
            clr_addr <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = clr_addr;
        clr_wr    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (clr_start) begin
                    state_nxt = ST_CLEAR;
                    cnt_nxt   = '0;
                end
            end
            ST_CLEAR: begin
                if (!disp_req) begin
                    clr_wr = 1'b1;
                    if (clr_addr == LAST_ADDR) begin
                        state_nxt = ST_IDLE;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = clr_addr + 1'b1;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign clr_busy = (state == ST_CLEAR);
`else
    logic unused_clr_start;
    assign unused_clr_start = clr_start;
    assign clr_busy = 1'b0;
    assign clr_wr   = 1'b0;
    assign clr_addr = '0;
`endif

    assign disp_win   = rst_n & disp_req;
    assign game_win   = rst_n & gp_req & ~disp_req & ~clr_busy;
    assign game_wr_ok = gp_we & ({1'b0, gp_addr} < DEPTH_W);
    assign gp_ack     = game_win;

    // With no winner the address bus parks on its last value.
    always_comb begin
        ram_a  = a_last;
        ram_d  = '0;
        ram_we = 1'b0;
        if (disp_win) begin
            ram_a = disp_addr;
        end else if (clr_wr) begin
            ram_a  = clr_addr;
            ram_d  = CLR_VAL;
            ram_we = 1'b1;
        end else if (game_win) begin
            ram_a  = gp_addr;
            ram_d  = gp_wdata;
            ram_we = game_wr_ok;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner     <= OWN_NONE;
            a_last    <= '0;
            disp_hold <= '0;
            gp_hold   <= '0;
        end else begin
            a_last <= ram_a;
            if (disp_win)
                owner <= OWN_DISP;
            else if (game_win && !gp_we)
                owner <= OWN_GAME;
            else
                owner <= OWN_NONE;
            if (owner == OWN_DISP)
                disp_hold <= ram_q;
            if (owner == OWN_GAME)
                gp_hold <= ram_q;
        end
    end

    // The RAM output register already supplies the one cycle of latency.
    assign disp_valid = (owner == OWN_DISP);
    assign gp_rvalid  = (owner == OWN_GAME);
    assign disp_data  = disp_valid ? ram_q : disp_hold;
    assign gp_rdata   = gp_rvalid ? ram_q : gp_hold;

endmodule
